// File: rtl/sn76489_register_decoder_pkg.sv
// sn76489_register_decoder_pkg: byte-field positions and latch register indices for the SN76489 writer
package sn76489_pkg;
  localparam int LATCH_BIT = 7;
  localparam int CH_MSB = 6;
  localparam int CH_LSB = 5;
  localparam int TYPE_BIT = 4;
  localparam logic [2:0] TONE0 = 3'd0;
  localparam logic [2:0] VOL0 = 3'd1;
  localparam logic [2:0] TONE1 = 3'd2;
  localparam logic [2:0] VOL1 = 3'd3;
  localparam logic [2:0] TONE2 = 3'd4;
  localparam logic [2:0] VOL2 = 3'd5;
  localparam logic [2:0] NOISE = 3'd6;
  localparam logic [2:0] VOL3 = 3'd7;
endpackage

// File: rtl/sn76489_register_decoder_if.sv
// sn76489_register_decoder_if: CPU write bus (wr strobe, data byte, ready back-pressure)
interface sn76489_register_decoder_if;
  logic wr;
  logic [7:0] data;
  logic ready;
  modport master (output wr, data, input ready);
  modport slave (input wr, data, output ready);
endinterface

// File: rtl/sn76489_register_decoder_ready_timer.sv
// sn76489_ready_timer: holds ready low for READY_CYCLES clocks after each accepted write (start)
module sn76489_ready_timer #(
  parameter int READY_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic ready
);
  localparam int W = $clog2(READY_CYCLES + 1);
  logic [W-1:0] cnt;
  assign ready = cnt == '0;
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (start) cnt <= W'(READY_CYCLES);
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/sn76489_register_decoder.sv
// sn76489_register_decoder: splits CPU bytes into latch/data writes and holds the PSG tone, noise and attenuator registers (ready timer under SN76489_READY_EN)
import sn76489_pkg::*;

module sn76489_register_decoder #(
  parameter int READY_CYCLES = 32,
  parameter logic [3:0] ATT_RESET = 4'hF
) (
  input  logic clk,
  input  logic reset,
  sn76489_register_decoder_if.slave bus,
  output logic [9:0] tone0_n,
  output logic [9:0] tone1_n,
  output logic [9:0] tone2_n,
  output logic [2:0] noise_ctrl,
  output logic [3:0] att0,
  output logic [3:0] att1,
  output logic [3:0] att2,
  output logic [3:0] att3,
  output logic noise_reset
);
  logic [2:0][9:0] tone;
  logic [3:0][3:0] att;
  logic [2:0] latch;
  logic accept;
  logic is_latch;
  logic [2:0] tgt;
  if (READY_CYCLES < 1) begin : g_bad_cycles
    $error("READY_CYCLES must be at least 1");
  end
`ifdef SN76489_READY_EN
  sn76489_ready_timer #(.READY_CYCLES(READY_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .start(accept),
    .ready(bus.ready)
  );
`else
  assign bus.ready = 1'b1;
`endif
  assign accept = bus.wr & bus.ready;
  assign is_latch = bus.data[LATCH_BIT];
  // a latch byte addresses its own register; a data byte reuses the stored latch
  assign tgt = is_latch ? bus.data[CH_MSB:TYPE_BIT] : latch;
  always_ff @(posedge clk) begin
    if (reset) begin
      tone <= '0;
      att <= {4{ATT_RESET}};
      noise_ctrl <= '0;
      latch <= TONE0;
      noise_reset <= 1'b0;
    end else begin
      noise_reset <= accept && tgt == NOISE;
      if (accept) begin
        if (is_latch) latch <= bus.data[CH_MSB:TYPE_BIT];
        if (tgt[0]) att[tgt[2:1]] <= bus.data[3:0];
        else if (tgt == NOISE) noise_ctrl <= bus.data[2:0];
        else if (is_latch) tone[tgt[2:1]][3:0] <= bus.data[3:0];
        else tone[tgt[2:1]][9:4] <= bus.data[5:0];
      end
    end
  end
  assign tone0_n = tone[0];
  assign tone1_n = tone[1];
  assign tone2_n = tone[2];
  assign att0 = att[0];
  assign att1 = att[1];
  assign att2 = att[2];
  assign att3 = att[3];
endmodule

// File: tb/tb_sn76489_register_decoder.sv
// tb_sn76489_register_decoder: directed self-checking bench for the SN76489 register decoder
module tb_sn76489_register_decoder;
  logic clk = 1'b0;
  logic reset;
  logic [9:0] tone0_n, tone1_n, tone2_n;
  logic [2:0] noise_ctrl;
  logic [3:0] att0, att1, att2, att3;
  logic noise_reset;
  int compared = 0;
  int mismatched = 0;
  sn76489_register_decoder_if bus ();
  sn76489_register_decoder dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .tone0_n(tone0_n),
    .tone1_n(tone1_n),
    .tone2_n(tone2_n),
    .noise_ctrl(noise_ctrl),
    .att0(att0),
    .att1(att1),
    .att2(att2),
    .att3(att3),
    .noise_reset(noise_reset)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr_byte(input logic [7:0] b);
    @(negedge clk);
    bus.wr = 1'b1;
    bus.data = b;
    @(negedge clk);
    bus.wr = 1'b0;
  endtask
  task automatic settle();
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", 32'(bus.ready), 32'd1);
  endtask
  initial begin
    int n;
    reset = 1'b1;
    bus.wr = 1'b0;
    bus.data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_tone0", 32'(tone0_n), 32'h0);
    check("rst_tone1", 32'(tone1_n), 32'h0);
    check("rst_tone2", 32'(tone2_n), 32'h0);
    check("rst_noise", 32'(noise_ctrl), 32'h0);
    check("rst_att", {16'h0, att0, att1, att2, att3}, 32'hFFFF);
    check("rst_ready", 32'(bus.ready), 32'h1);
    check("rst_nrst", 32'(noise_reset), 32'h0);
    wr_byte(8'h8E);
    check("tone0_low", 32'(tone0_n), 32'h00E);
    settle();
    wr_byte(8'h0F);
    check("tone0_full", 32'(tone0_n), 32'h0FE);
    check("tone1_keep", 32'(tone1_n), 32'h0);
    check("tone2_keep", 32'(tone2_n), 32'h0);
    settle();
    wr_byte(8'h91);
    check("att0_latch", 32'(att0), 32'h1);
    settle();
    wr_byte(8'h07);
    check("att0_data", 32'(att0), 32'h7);
    check("tone0_untouched", 32'(tone0_n), 32'h0FE);
    settle();
    wr_byte(8'hE5);
    check("noise_latch", 32'(noise_ctrl), 32'h5);
    check("nrst_pulse1", 32'(noise_reset), 32'h1);
    @(negedge clk);
    check("nrst_end1", 32'(noise_reset), 32'h0);
    settle();
    wr_byte(8'h03);
    check("noise_data", 32'(noise_ctrl), 32'h3);
    check("nrst_pulse2", 32'(noise_reset), 32'h1);
    @(negedge clk);
    check("nrst_end2", 32'(noise_reset), 32'h0);
    settle();
    wr_byte(8'hA3);
    check("tone1_low", 32'(tone1_n), 32'h003);
    repeat (4) @(negedge clk);
    wr_byte(8'hBF);
    wr_byte(8'h02);
`ifdef SN76489_READY_EN
    check("drop_att1", 32'(att1), 32'hF);
    check("drop_tone1", 32'(tone1_n), 32'h003);
    settle();
    wr_byte(8'h84);
    check("tone2_low", 32'(tone2_n), 32'h004);
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_len", 32'(n), 32'd32);
    wr_byte(8'h82);
    check("wr_at_ready", 32'(tone2_n), 32'h002);
`else
    check("accept_att1", 32'(att1), 32'h2);
    check("accept_tone1", 32'(tone1_n), 32'h003);
    @(negedge clk);
    bus.wr = 1'b1;
    bus.data = 8'hE4;
    @(negedge clk);
    bus.data = 8'h06;
    check("b2b_noise1", 32'(noise_ctrl), 32'h4);
    check("b2b_nrst1", 32'(noise_reset), 32'h1);
    @(negedge clk);
    bus.wr = 1'b0;
    check("b2b_noise2", 32'(noise_ctrl), 32'h6);
    check("b2b_nrst2", 32'(noise_reset), 32'h1);
    @(negedge clk);
    check("b2b_nrst_end", 32'(noise_reset), 32'h0);
`endif
    settle();
    wr_byte(8'h90);
    check("att0_zero", 32'(att0), 32'h0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_ready", 32'(bus.ready), 32'h1);
    check("mid_rst_att", {16'h0, att0, att1, att2, att3}, 32'hFFFF);
    check("mid_rst_tones", {2'b0, tone0_n, tone1_n, tone2_n}, 32'h0);
    check("mid_rst_noise", 32'(noise_ctrl), 32'h0);
    wr_byte(8'h0A);
    check("latch_rst_tone0", 32'(tone0_n), 32'h0A0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
